// File: rtl/dmem_block_responder.sv
// Block-granular data memory behind the data cache: one 128-bit read or write
// at a time, stalled for LATENCY busy cycles, then a single DONE cycle.
module dmem_block_responder #(
  parameter int DEPTH_BLOCKS = 256,
  parameter int LATENCY      = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MEM_READ,
  input  logic         MEM_WRITE,
  input  logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_WRITEDATA,
  output logic [127:0] MEM_READDATA,
  output logic         MEM_BUSYWAIT
);
  localparam int IW = $clog2(DEPTH_BLOCKS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic          wr;
    logic [IW-1:0] idx;
    logic [127:0]  data;
  } req_t;

  logic [127:0] mem [DEPTH_BLOCKS];
  state_t       state;
  req_t         req;
  logic [CW-1:0] cnt;
  logic         commit;

  // Upper block-address bits alias; they are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^MEM_ADDRESS[27:IW];

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & (state != DONE);
  assign commit       = (state == BUSY) && (cnt == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      req          <= '0;
      MEM_READDATA <= '0;
    end else begin
      case (state)
        IDLE: if (MEM_READ | MEM_WRITE) begin
          // Write wins when both are requested.
          req.wr   <= MEM_WRITE;
          req.idx  <= MEM_ADDRESS[IW-1:0];
          req.data <= MEM_WRITEDATA;
          cnt      <= CW'(LATENCY - 1);
          state    <= BUSY;
        end
        BUSY: if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          if (!req.wr) MEM_READDATA <= mem[req.idx];
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; reset forces IDLE so a pending write never commits.
  always_ff @(posedge CLK) begin
    if (commit && req.wr) mem[req.idx] <= req.data;
  end
endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed + randomized bench for dmem_block_responder against a block-level
// memory model that tracks array contents and the last returned read block.
module tb_dmem_block_responder;
  localparam int L = 4;
  localparam int DEPTH = 256;

  logic         CLK, RESET, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  logic         MEM_BUSYWAIT;

  dmem_block_responder #(.DEPTH_BLOCKS(DEPTH), .LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] mdl [DEPTH];
  bit           mval [DEPTH];
  logic [127:0] last_rd = '0;
  bit           last_known = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge on which the
  // requester would drop its request (cycle L+2 of the transaction).
  task automatic txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
    int idx;
    logic [127:0] exp_rd;
    bit exp_known;
    idx = int'(a) % DEPTH;
    if (wr) begin
      exp_rd = last_rd; exp_known = last_known;
    end else begin
      exp_rd = mdl[idx]; exp_known = mval[idx];
    end
    MEM_READ = rd; MEM_WRITE = wr; MEM_ADDRESS = a; MEM_WRITEDATA = d;
    for (int c = 0; c <= L + 1; c++) begin
      @(negedge CLK);
      chk("busywait", {127'd0, MEM_BUSYWAIT}, {127'd0, c <= L});
      if (c == L && last_known) chk("rdata_hold", MEM_READDATA, last_rd);
      if (c == L + 1 && exp_known) chk(wr ? "rdata_keep" : "rdata", MEM_READDATA, exp_rd);
    end
    @(posedge CLK); #1;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    if (wr) begin mdl[idx] = d; mval[idx] = 1'b1; end
    last_rd = exp_rd; last_known = exp_known;
  endtask

  initial begin
    logic [127:0] blk5, ones, aa, fives;
    blk5  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    ones  = '1;
    aa    = {16{8'hAA}};
    fives = {16{8'h55}};
    for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;

    // Reset and idle
    RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; MEM_ADDRESS = '0; MEM_WRITEDATA = '0;
    @(negedge CLK);
    chk("rst_rdata", MEM_READDATA, '0);
    chk("rst_bw", {127'd0, MEM_BUSYWAIT}, '0);
    @(posedge CLK); #1 RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("idle_bw", {127'd0, MEM_BUSYWAIT}, '0);
      chk("idle_rdata", MEM_READDATA, '0);
    end
    @(posedge CLK); #1;

    // Write then read
    txn(0, 1, 28'h0000005, blk5);
    txn(1, 0, 28'h0000005, 128'h0);

    // Aliasing modulo depth
    txn(0, 1, 28'h0000004, 128'h4);
    txn(0, 1, 28'h0000103, 128'h1);
    txn(1, 0, 28'h0000003, 128'h0);
    txn(1, 0, 28'h0000004, 128'h0);

    // Read+write together behaves as write
    txn(1, 1, 28'h0000006, 128'h66);
    txn(1, 0, 28'h0000006, 128'h0);

    // Inputs changed / request dropped mid-BUSY
    txn(0, 1, 28'h0000008, 128'h8888);
    MEM_WRITE = 1'b1; MEM_ADDRESS = 28'h7; MEM_WRITEDATA = aa;
    @(posedge CLK); #1;
    MEM_WRITE = 1'b0; MEM_ADDRESS = 28'h8; MEM_WRITEDATA = fives;
    @(negedge CLK);
    chk("drop_bw", {127'd0, MEM_BUSYWAIT}, '0);
    repeat (L + 1) @(posedge CLK);
    #1;
    mdl[7] = aa; mval[7] = 1'b1;
    txn(1, 0, 28'h0000007, 128'h0);
    txn(1, 0, 28'h0000008, 128'h0);

    // Back-to-back reads with request held through DONE
    MEM_READ = 1'b1; MEM_ADDRESS = 28'h5;
    for (int c = 0; c <= 2 * L + 3; c++) begin
      @(negedge CLK);
      chk("b2b_bw", {127'd0, MEM_BUSYWAIT}, {127'd0, !(c == L + 1 || c == 2 * L + 3)});
      if (c == L + 1 || c == 2 * L + 3) chk("b2b_rdata", MEM_READDATA, blk5);
    end
    @(posedge CLK); #1 MEM_READ = 1'b0;
    last_rd = blk5; last_known = 1'b1;

    // Reset during second BUSY cycle of a write
    txn(0, 1, 28'h0000009, 128'h0);
    txn(1, 0, 28'h0000005, 128'h0);
    MEM_WRITE = 1'b1; MEM_ADDRESS = 28'h9; MEM_WRITEDATA = ones;
    @(posedge CLK); #1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rstw_rdata", MEM_READDATA, '0);
    chk("rstw_bw", {127'd0, MEM_BUSYWAIT}, 128'd1);
    MEM_WRITE = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstw_rdata2", MEM_READDATA, '0);
    chk("rstw_bw2", {127'd0, MEM_BUSYWAIT}, '0);
    @(posedge CLK); #1 RESET = 1'b1;
    last_rd = '0; last_known = 1'b1;
    txn(1, 0, 28'h0000009, 128'h0);

    // Randomized traffic over a small block set with aliased upper bits
    for (int t = 0; t < 40; t++) begin
      int op, gap;
      logic [27:0] a;
      op  = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 2));
      a   = {20'($urandom), 8'($urandom_range(0, 15))};
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        chk("gap_bw", {127'd0, MEM_BUSYWAIT}, '0);
        @(posedge CLK); #1;
      end
      txn(op != 1, op != 0, a, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
